// File: rtl/sirv_expl_axi_mst_pkg.sv
// Shared FSM encoding and AXI protocol constants for the example AXI master.
// Pure declarations; no timing or backpressure of its own.
package sirv_expl_axi_mst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_RD   = 3'd2,
    ST_AW   = 3'd3,
    ST_WR   = 3'd4,
    ST_BR   = 3'd5
  } mst_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

  // SLVERR and DECERR are exactly the responses with resp[1] set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/sirv_expl_axi_mst_if.sv
// Command/write-data/response side plus AXI master-side bus of the example AXI master.
// mst is the initiator's view; slv is the view of whoever drives commands and models the slave.
interface sirv_expl_axi_mst_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cmd_valid, cmd_ready, cmd_read;
  logic [AW-1:0]   cmd_addr;
  logic [3:0]      cmd_len;
  logic            wd_valid, wd_ready;
  logic [DW-1:0]   wd_data;
  logic [DW/8-1:0] wd_strb;
  logic            rsp_valid, rsp_ready, rsp_err, rsp_last;
  logic [DW-1:0]   rsp_rdata;
  logic            proto_err;

  logic            axi_arvalid, axi_arready;
  logic [AW-1:0]   axi_araddr;
  logic [3:0]      axi_arlen, axi_arcache;
  logic [2:0]      axi_arsize, axi_arprot;
  logic [1:0]      axi_arburst, axi_arlock;
  logic            axi_awvalid, axi_awready;
  logic [AW-1:0]   axi_awaddr;
  logic [3:0]      axi_awlen, axi_awcache;
  logic [2:0]      axi_awsize, axi_awprot;
  logic [1:0]      axi_awburst, axi_awlock;
  logic            axi_wvalid, axi_wready, axi_wlast;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_rvalid, axi_rready, axi_rlast;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_bvalid, axi_bready;
  logic [1:0]      axi_bresp;

  modport mst (
    input  cmd_valid, cmd_read, cmd_addr, cmd_len, wd_valid, wd_data, wd_strb, rsp_ready,
           axi_arready, axi_awready, axi_wready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
           axi_bvalid, axi_bresp,
    output cmd_ready, wd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_last, proto_err,
           axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arcache,
           axi_arprot, axi_arlock, axi_awvalid, axi_awaddr, axi_awlen, axi_awsize,
           axi_awburst, axi_awcache, axi_awprot, axi_awlock, axi_wvalid, axi_wdata,
           axi_wstrb, axi_wlast, axi_rready, axi_bready
  );

  modport slv (
    output cmd_valid, cmd_read, cmd_addr, cmd_len, wd_valid, wd_data, wd_strb, rsp_ready,
           axi_arready, axi_awready, axi_wready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
           axi_bvalid, axi_bresp,
    input  cmd_ready, wd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_last, proto_err,
           axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arcache,
           axi_arprot, axi_arlock, axi_awvalid, axi_awaddr, axi_awlen, axi_awsize,
           axi_awburst, axi_awcache, axi_awprot, axi_awlock, axi_wvalid, axi_wdata,
           axi_wstrb, axi_wlast, axi_rready, axi_bready
  );
endinterface

// File: rtl/sirv_expl_axi_mst.sv
// Single-outstanding AXI3 INCR master; AR/AW one cycle after cmd accept, cmd_ready one cycle after final R/B.
// rsp_ready drives rready/bready and wd_valid drives wvalid directly, so stalls on either side propagate with no buffering.
module sirv_expl_axi_mst
  import sirv_expl_axi_mst_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic             clk,
  input logic             rst,
  sirv_expl_axi_mst_if.mst bus
);

  mst_state_e    state, nxt;
  logic [3:0]    cnt, len_q;
  logic [AW-1:0] addr_q;
  logic          proto_q;
  logic          last, r_hs, w_hs;

  assign last = (cnt == len_q);
  assign r_hs = (state == ST_RD) && bus.axi_rvalid && bus.rsp_ready;
  assign w_hs = (state == ST_WR) && bus.wd_valid && bus.axi_wready;

  assign bus.axi_araddr  = addr_q;
  assign bus.axi_arlen   = len_q;
  assign bus.axi_arsize  = axi_size(DW);
  assign bus.axi_arburst = AXI_BURST_INCR;
  assign bus.axi_arcache = 4'b0000;
  assign bus.axi_arprot  = 3'b000;
  assign bus.axi_arlock  = 2'b00;
  assign bus.axi_awaddr  = addr_q;
  assign bus.axi_awlen   = len_q;
  assign bus.axi_awsize  = axi_size(DW);
  assign bus.axi_awburst = AXI_BURST_INCR;
  assign bus.axi_awcache = 4'b0000;
  assign bus.axi_awprot  = 3'b000;
  assign bus.axi_awlock  = 2'b00;
  assign bus.axi_wdata   = bus.wd_data;
  assign bus.axi_wstrb   = bus.wd_strb;
  assign bus.proto_err   = proto_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      len_q   <= 4'd0;
      addr_q  <= '0;
      proto_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && bus.cmd_valid) begin
        addr_q <= bus.cmd_addr;
        len_q  <= bus.cmd_len;
      end
      if (r_hs || w_hs) cnt <= last ? 4'd0 : cnt + 4'd1;
      if (r_hs && (bus.axi_rlast != last)) proto_q <= 1'b1;
    end
  end

  always_comb begin
    nxt             = state;
    bus.cmd_ready   = 1'b0;
    bus.wd_ready    = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_rdata   = '0;
    bus.rsp_err     = 1'b0;
    bus.rsp_last    = 1'b0;
    bus.axi_arvalid = 1'b0;
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid  = 1'b0;
    bus.axi_wlast   = 1'b0;
    bus.axi_rready  = 1'b0;
    bus.axi_bready  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Held low during reset so a command offered then is not seen as accepted.
        bus.cmd_ready = !rst;
        if (bus.cmd_valid) nxt = bus.cmd_read ? ST_AR : ST_AW;
      end
      ST_AR: begin
        bus.axi_arvalid = 1'b1;
        if (bus.axi_arready) nxt = ST_RD;
      end
      ST_RD: begin
        bus.axi_rready = bus.rsp_ready;
        bus.rsp_valid  = bus.axi_rvalid;
        bus.rsp_rdata  = bus.axi_rdata;
        bus.rsp_err    = resp_is_err(bus.axi_rresp);
        bus.rsp_last   = last;
        if (r_hs && last) nxt = ST_IDLE;
      end
      ST_AW: begin
        bus.axi_awvalid = 1'b1;
        if (bus.axi_awready) nxt = ST_WR;
      end
      ST_WR: begin
        bus.axi_wvalid = bus.wd_valid;
        bus.wd_ready   = bus.axi_wready;
        bus.axi_wlast  = last;
        if (w_hs && last) nxt = ST_BR;
      end
      ST_BR: begin
        bus.axi_bready = bus.rsp_ready;
        bus.rsp_valid  = bus.axi_bvalid;
        bus.rsp_err    = resp_is_err(bus.axi_bresp);
        bus.rsp_last   = 1'b1;
        if (bus.axi_bvalid && bus.rsp_ready) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sirv_expl_axi_mst.sv
// Directed and random transactions against a transaction-level reference of the AXI master,
// with the bench acting as both command source and AXI slave.
module tb_sirv_expl_axi_mst;

  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nerr = 0;
  bit   exp_proto = 1'b0;

  always #5 clk = ~clk;

  sirv_expl_axi_mst_if #(.AW(32), .DW(32)) bus ();
  sirv_expl_axi_mst #(.AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid = 0; bus.cmd_read = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wd_valid = 0; bus.wd_data = '0; bus.wd_strb = '0; bus.rsp_ready = 0;
    bus.axi_arready = 0; bus.axi_awready = 0; bus.axi_wready = 0;
    bus.axi_rvalid = 0; bus.axi_rdata = '0; bus.axi_rresp = '0; bus.axi_rlast = 0;
    bus.axi_bvalid = 0; bus.axi_bresp = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".arvalid"}, bus.axi_arvalid, 0);
    chk({tag, ".awvalid"}, bus.axi_awvalid, 0);
    chk({tag, ".wvalid"}, bus.axi_wvalid, 0);
    chk({tag, ".rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, ".wd_ready"}, bus.wd_ready, 0);
    chk({tag, ".rready"}, bus.axi_rready, 0);
    chk({tag, ".bready"}, bus.axi_bready, 0);
  endtask

  // One command end to end. rsp_mode: 0 random, 1 toggle, 2 always ready.
  // bad >= 0 puts the slave's rlast on that beat instead of the real last one.
  // abort_at >= 0 applies reset at that cycle and abandons the transaction.
  task automatic txn(input bit rd, input logic [31:0] addr, input int len, input int a_delay,
                     input int rsp_mode, input int bad, input logic [1:0] bresp_v,
                     input int abort_at, input bit seq, input logic [31:0] d0, input bit rand_err);
    logic [31:0] dat[16];
    logic [3:0]  stb[16];
    logic [1:0]  rr[16];
    int rbeat = 0, wbeat = 0, wait_a = 0, cyc = 0, ri, wi;
    bit cmd_done = 0, a_done = 0, done = 0;
    for (int i = 0; i < 16; i++) begin
      dat[i] = seq ? 32'h11 * (i + 1) : $urandom;
      stb[i] = seq ? 4'hF : 4'($urandom);
      rr[i]  = rand_err ? 2'($urandom) : 2'b00;
    end
    if (d0 != 0) dat[0] = d0;
    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      if (cyc == abort_at) begin
        rst = 1; idle_inputs();
        @(posedge clk); @(negedge clk);
        chk_quiet("abort");
        chk("abort.cmd_ready", bus.cmd_ready, 0);
        chk("abort.proto_err", bus.proto_err, 0);
        exp_proto = 0;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("abort.cmd_ready_after", bus.cmd_ready, 1);
        return;
      end
      ri = (rbeat > 15) ? 15 : rbeat;
      wi = (wbeat > 15) ? 15 : wbeat;
      bus.cmd_valid   = !cmd_done;
      bus.cmd_read    = rd;
      bus.cmd_addr    = addr;
      bus.cmd_len     = 4'(len);
      bus.axi_arready = rd && (wait_a >= a_delay);
      bus.axi_awready = !rd && (wait_a >= a_delay);
      bus.axi_rvalid  = rd && a_done && rbeat <= len && ($urandom_range(0, 3) != 0);
      bus.axi_rdata   = dat[ri];
      bus.axi_rresp   = rr[ri];
      bus.axi_rlast   = (bad >= 0) ? (rbeat == bad) : (rbeat == len);
      bus.wd_valid    = !rd && wbeat <= len && ($urandom_range(0, 3) != 0);
      bus.wd_data     = dat[wi];
      bus.wd_strb     = stb[wi];
      bus.axi_wready  = ($urandom_range(0, 3) != 0);
      bus.axi_bvalid  = !rd && wbeat > len && ($urandom_range(0, 2) != 0);
      bus.axi_bresp   = bresp_v;
      bus.rsp_ready   = (rsp_mode == 1) ? cyc[0] : (rsp_mode == 2) ? 1'b1 : 1'($urandom);
      @(negedge clk);
      chk("proto_err", bus.proto_err, exp_proto);
      chk("cmd_ready", bus.cmd_ready, !cmd_done);
      chk("arvalid", bus.axi_arvalid, rd && cmd_done && !a_done);
      chk("awvalid", bus.axi_awvalid, !rd && cmd_done && !a_done);
      if (bus.axi_arvalid) begin
        chk("araddr", bus.axi_araddr, addr);
        chk("arlen", bus.axi_arlen, len);
      end
      if (bus.axi_awvalid) begin
        chk("awaddr", bus.axi_awaddr, addr);
        chk("awlen", bus.axi_awlen, len);
      end
      chk("wvalid", bus.axi_wvalid, !rd && a_done && bus.wd_valid);
      chk("wd_ready", bus.wd_ready, !rd && a_done && wbeat <= len && bus.axi_wready);
      if (bus.axi_wvalid) begin
        chk("wdata", bus.axi_wdata, dat[wi]);
        chk("wstrb", bus.axi_wstrb, stb[wi]);
        chk("wlast", bus.axi_wlast, wbeat == len);
      end
      chk("rready", bus.axi_rready, (rd && a_done && rbeat <= len) ? bus.rsp_ready : 1'b0);
      chk("bready", bus.axi_bready, (!rd && wbeat > len) ? bus.rsp_ready : 1'b0);
      chk("rsp_valid", bus.rsp_valid, rd ? bus.axi_rvalid : bus.axi_bvalid);
      if (bus.rsp_valid) begin
        chk("rsp_rdata", bus.rsp_rdata, rd ? dat[ri] : 32'h0);
        chk("rsp_err", bus.rsp_err, rd ? rr[ri][1] : bresp_v[1]);
        chk("rsp_last", bus.rsp_last, rd ? (rbeat == len) : 1'b1);
      end
      if (bus.cmd_valid && bus.cmd_ready) cmd_done = 1;
      if (bus.axi_arvalid || bus.axi_awvalid) begin
        if (bus.axi_arready || bus.axi_awready) a_done = 1;
        else wait_a++;
      end
      if (rd && bus.axi_rvalid && bus.axi_rready) begin
        if (bus.axi_rlast != (rbeat == len)) exp_proto = 1;
        rbeat++;
        if (rbeat > len) done = 1;
      end
      if (bus.axi_wvalid && bus.axi_wready) wbeat++;
      if (!rd && bus.axi_bvalid && bus.axi_bready) done = 1;
      cyc++;
    end
    chk("timeout", done, 1);
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    chk("cmd_ready_after", bus.cmd_ready, 1);
    chk_quiet("after");
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset.cmd_ready", bus.cmd_ready, 0);
    chk("reset.proto_err", bus.proto_err, 0);
    chk("arburst", bus.axi_arburst, 2'b01);
    chk("awburst", bus.axi_awburst, 2'b01);
    chk("arsize", bus.axi_arsize, 3'd2);
    chk("awsize", bus.axi_awsize, 3'd2);
    chk("cache", {bus.axi_arcache, bus.axi_awcache}, 8'h00);
    chk("prot", {bus.axi_arprot, bus.axi_awprot}, 6'h00);
    chk("lock", {bus.axi_arlock, bus.axi_awlock}, 4'h0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("reset.cmd_ready_after", bus.cmd_ready, 1);

    // single-beat read
    txn(1, 32'h1000, 0, 0, 2, -1, 2'b00, -1, 0, 32'hDEADBEEF, 0);
    // 4-beat write with slow awready
    txn(0, 32'h2000, 3, 3, 2, -1, 2'b00, -1, 1, 32'h0, 0);
    // 16-beat read with toggling rsp_ready
    txn(1, 32'h3000, 15, 1, 1, -1, 2'b00, -1, 0, 32'h0, 0);
    // early rlast on beat 2 of 4
    txn(1, 32'h4000, 3, 0, 2, 1, 2'b00, -1, 0, 32'h0, 0);
    chk("proto_sticky", bus.proto_err, 1);
    // SLVERR write response, then reset in the middle of a write burst
    txn(0, 32'h5000, 2, 0, 2, -1, 2'b10, -1, 0, 32'h0, 0);
    chk("proto_still_set", bus.proto_err, 1);
    txn(0, 32'h6000, 7, 0, 0, -1, 2'b00, 6, 0, 32'h0, 0);
    chk("proto_cleared", bus.proto_err, 0);

    for (int t = 0; t < 20; t++) begin
      txn(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 15), $urandom_range(0, 3),
          0, -1, 2'($urandom), -1, 0, 32'h0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
